// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared widths and register-index constants for the GPR file
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PEND_W_DEF = 2;
    localparam int REG_COUNT  = 32;
    localparam int ZERO_REG   = 0;
    localparam int RA_REG     = 31;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write counters, pending flags, sticky overflow
import reg_file_pkg::*;

module reg_scoreboard #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic              read_en_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic              read_en_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic              pending_1,
    output logic              pending_2,
    output logic              sb_overflow
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [PEND_W-1:0] cnt      [NREG];
    logic [PEND_W-1:0] cnt_next [NREG];
    logic              ovf_set;
    logic              inc;
    logic              dec;

    // A retire against a zero counter (e.g. after a flush) is simply ignored.
    always_comb begin
        ovf_set = 1'b0;
        inc     = 1'b0;
        dec     = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            inc = issue_en && !flush && (issue_addr == ADDR_W'(r)) && (r != 0);
            dec = write_en && (write_addr == ADDR_W'(r)) && (cnt[r] != '0);
            cnt_next[r] = cnt[r];
            if (flush) begin
                cnt_next[r] = '0;
            end else if (inc && !dec) begin
                if (cnt[r] == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_next[r] = cnt[r] + CNT_ONE;
                end
            end else if (dec && !inc) begin
                cnt_next[r] = cnt[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            sb_overflow <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= cnt_next[r];
            end
            if (ovf_set) begin
                sb_overflow <= 1'b1;
            end
        end
    end

    // A last outstanding write retiring this cycle is covered by the WB bypass.
    always_comb begin
        pending_1 = read_en_1 && (read_addr_1 != '0) && (cnt[read_addr_1] != '0)
                    && !((cnt[read_addr_1] == CNT_ONE) && write_en && (write_addr == read_addr_1));
        pending_2 = read_en_2 && (read_addr_2 != '0) && (cnt[read_addr_2] != '0)
                    && !((cnt[read_addr_2] == CNT_ONE) && write_en && (write_addr == read_addr_2));
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - MIPS GPR file: 2 read ports with WB bypass, write port, scoreboard
// Optional raw debug read port under `REG_FILE_DEBUG_PORT_EN.
import reg_file_pkg::*;

module reg_file #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en_1,
    input  logic [ADDR_W-1:0] read_addr_1,
    output logic [DATA_W-1:0] read_data_1,
    input  logic              read_en_2,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_2,
    output logic              pending_1,
    output logic              pending_2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              flush,
    output logic              sb_overflow
`ifdef REG_FILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] debug_addr,
    output logic [DATA_W-1:0] debug_data
`endif
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (write_en && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    always_comb begin
        read_data_1 = '0;
        if (read_en_1 && (read_addr_1 != '0)) begin
            read_data_1 = (write_en && (write_addr == read_addr_1)) ? write_data : regs[read_addr_1];
        end
        read_data_2 = '0;
        if (read_en_2 && (read_addr_2 != '0)) begin
            read_data_2 = (write_en && (write_addr == read_addr_2)) ? write_data : regs[read_addr_2];
        end
    end

`ifdef REG_FILE_DEBUG_PORT_EN
    assign debug_data = (debug_addr == '0) ? '0 : regs[debug_addr];
`endif

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .PEND_W (PEND_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .pending_1   (pending_1),
        .pending_2   (pending_2),
        .sb_overflow (sb_overflow)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed and randomized checks of reg_file against a reference model
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        read_en_1, read_en_2, issue_en, write_en, flush;
    logic [4:0]  read_addr_1, read_addr_2, issue_addr, write_addr;
    logic [31:0] read_data_1, read_data_2, write_data;
    logic        pending_1, pending_2, sb_overflow;
`ifdef REG_FILE_DEBUG_PORT_EN
    logic [4:0]  debug_addr;
    logic [31:0] debug_data;
`endif

    always #5 clk = ~clk;

    reg_file dut (
        .clk         (clk),
        .rst         (rst),
        .read_en_1   (read_en_1),
        .read_addr_1 (read_addr_1),
        .read_data_1 (read_data_1),
        .read_en_2   (read_en_2),
        .read_addr_2 (read_addr_2),
        .read_data_2 (read_data_2),
        .pending_1   (pending_1),
        .pending_2   (pending_2),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .flush       (flush),
        .sb_overflow (sb_overflow)
`ifdef REG_FILE_DEBUG_PORT_EN
        ,
        .debug_addr  (debug_addr),
        .debug_data  (debug_data)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0) return 32'h0;
        if (write_en && write_addr == a) return write_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_pend(input logic en, input logic [4:0] a);
        if (!en || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        if (m_cnt[a] == 1 && write_en && write_addr == a) return 1'b0;
        return 1'b1;
    endfunction

    // Applies the rising-edge effect of the current inputs to the model.
    task automatic model_edge();
        int nc [32];
        nc = m_cnt;
        if (flush) begin
            for (int i = 0; i < 32; i++) nc[i] = 0;
        end else begin
            if (issue_en && issue_addr != 5'd0) nc[issue_addr] = nc[issue_addr] + 1;
            if (write_en && m_cnt[write_addr] > 0) nc[write_addr] = nc[write_addr] - 1;
            if (issue_en && issue_addr != 5'd0 && nc[issue_addr] > 3) begin
                nc[issue_addr] = 3;
                m_ovf = 1'b1;
            end
        end
        m_cnt = nc;
        if (write_en && write_addr != 5'd0) m_reg[write_addr] = write_data;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd1"}, read_data_1, exp_rd(read_en_1, read_addr_1));
        check({tag, ".rd2"}, read_data_2, exp_rd(read_en_2, read_addr_2));
        check({tag, ".p1"}, {31'h0, pending_1}, {31'h0, exp_pend(read_en_1, read_addr_1)});
        check({tag, ".p2"}, {31'h0, pending_2}, {31'h0, exp_pend(read_en_2, read_addr_2)});
        check({tag, ".ovf"}, {31'h0, sb_overflow}, {31'h0, m_ovf});
`ifdef REG_FILE_DEBUG_PORT_EN
        check({tag, ".dbg"}, debug_data, m_reg[debug_addr]);
`endif
    endtask

    task automatic set_in(input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2,
                          input logic ie, input logic [4:0] ia, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic fl);
        read_en_1 = re1; read_addr_1 = ra1; read_en_2 = re2; read_addr_2 = ra2;
        issue_en = ie; issue_addr = ia; write_en = we; write_addr = wa; write_data = wd; flush = fl;
`ifdef REG_FILE_DEBUG_PORT_EN
        debug_addr = 5'($urandom_range(0, 31));
`endif
    endtask

    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b0;
        model_reset();
        set_in(1, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        for (int i = 0; i < 32; i++) begin
            read_addr_1 = 5'(i);
            read_addr_2 = 5'(31 - i);
            #1;
            check("reset_rd1", read_data_1, 32'h0);
            check("reset_rd2", read_data_2, 32'h0);
            check("reset_pend", {30'h0, pending_1, pending_2}, 32'h0);
        end
        check("reset_ovf", {31'h0, sb_overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        set_in(0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        cycle("wr5");
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("rd5", read_data_1, 32'hDEADBEEF);
        cycle("rd5m");

        set_in(0, 0, 0, 0, 0, 0, 1, 0, 32'h1234, 0);
        cycle("wr0");
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("rd0", read_data_1, 32'h0);
        cycle("rd0m");

        set_in(0, 0, 1, 7, 0, 0, 1, 7, 32'hA5A5A5A5, 0);
        #1;
        check("bypass", read_data_2, 32'hA5A5A5A5);
        cycle("bypassm");

        set_in(0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 0);
        cycle("iss9a");
        cycle("iss9b");
        set_in(1, 9, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("pend9_2", {31'h0, pending_1}, 32'h1);
        cycle("pend9_2m");
        set_in(1, 9, 0, 0, 0, 0, 1, 9, 32'h99, 0);
        #1;
        check("pend9_wb1", {31'h0, pending_1}, 32'h1);
        cycle("wb9a");
        #1;
        check("pend9_wb2", {31'h0, pending_1}, 32'h0);
        cycle("wb9b");
        set_in(1, 9, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("pend9_done", {31'h0, pending_1}, 32'h0);
        check("rd9", read_data_1, 32'h99);
        cycle("done9");

        set_in(0, 0, 1, 3, 1, 3, 0, 0, 32'h0, 0);
        for (int i = 0; i < 4; i++) cycle("iss3");
        #1;
        check("sat_ovf", {31'h0, sb_overflow}, 32'h1);
        check("sat_pend", {31'h0, pending_2}, 32'h1);
        set_in(0, 0, 1, 3, 1, 3, 0, 0, 32'h0, 1);
        cycle("flush");
        set_in(0, 0, 1, 3, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("flush_pend", {31'h0, pending_2}, 32'h0);
        check("flush_ovf", {31'h0, sb_overflow}, 32'h1);
        cycle("flushm");
        set_in(0, 0, 0, 0, 0, 0, 1, 3, 32'h33, 0);
        cycle("wb3");
        set_in(0, 0, 1, 3, 0, 0, 0, 0, 32'h0, 0);
        #1;
        check("rd3", read_data_2, 32'h33);
        check("pend3", {31'h0, pending_2}, 32'h0);
        cycle("rd3m");

        set_in(0, 0, 0, 0, 0, 0, 1, 12, 32'h1111, 0);
        cycle("wr12");
        set_in(1, 12, 0, 0, 0, 0, 1, 12, 32'hCAFEF00D, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        write_en = 1'b0;
        #1;
        check("arst_rd12", read_data_1, 32'h0);
        check("arst_ovf", {31'h0, sb_overflow}, 32'h0);
        write_en = 1'b1;
        @(posedge clk);
        #1;
        write_en = 1'b0;
        #1;
        check("arst_edge_rd12", read_data_1, 32'h0);
`ifdef REG_FILE_DEBUG_PORT_EN
        debug_addr = 5'd12;
        #1;
        check("arst_dbg12", debug_data, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
                   1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                   5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 19) == 0));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
